// File: rtl/nabp_filtered_line_buffer_pkg.sv
// Shared constants for the NABP filtered-line capture path.
// Sample width, ramp-filter latency and projection line length.
package nabp_filtered_line_buffer_pkg;

    localparam int kFilteredDataLength = 16;
    localparam int kFilterLatency      = 3;
    localparam int kLineLength         = 256;

endpackage

// File: rtl/nabp_filtered_line_buffer_dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The output register is cleared by reset so rd_data starts at zero.
module nabp_dual_port_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/nabp_filtered_line_buffer.sv
// Ping-pong line buffer behind the ramp filter: skips the filter latency,
// captures one line per free bank and hands completed banks to the reader.
module nabp_filtered_line_buffer
    import nabp_filtered_line_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = kFilteredDataLength,
    parameter int LINE_LENGTH = kLineLength,
    parameter int SKIP        = kFilterLatency,
    parameter int ADDR_WIDTH  = $clog2(LINE_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [DATA_WIDTH-1:0] val_in,
    output logic                  busy,
    output logic                  overflow,
    output logic                  line_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  line_release
);

    localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_FILL
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [SKW-1:0]        r_skip_cnt;
    logic [SKW-1:0]        w_skip_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_idx;
    logic [ADDR_WIDTH-1:0] w_wr_idx_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic                  w_wr_en;
    logic                  w_complete;
    logic                  w_release;
    logic [1:0]            r_bank_valid;
    logic [1:0]            w_bank_valid_nxt;
    logic                  r_wr_bank;
    logic                  r_rd_bank;

    // A line_start always restarts capture; a partial line never marks its
    // bank valid, so an abort reuses the same bank without overflow.
    always_comb begin
        w_state_nxt    = r_state;
        w_skip_cnt_nxt = r_skip_cnt;
        w_wr_idx_nxt   = r_wr_idx;
        w_wr_idx       = r_wr_idx;
        w_wr_en        = 1'b0;
        w_complete     = 1'b0;
        if (line_start) begin
            if (!r_bank_valid[r_wr_bank]) begin
                if (SKIP == 0) begin
                    w_wr_en      = 1'b1;
                    w_wr_idx     = '0;
                    w_wr_idx_nxt = ADDR_WIDTH'(1);
                    w_state_nxt  = ST_FILL;
                end else begin
                    w_skip_cnt_nxt = SKW'(1);
                    w_state_nxt    = ST_SKIP;
                end
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_SKIP: begin
                    if (r_skip_cnt == SKW'(SKIP)) begin
                        w_wr_en      = 1'b1;
                        w_wr_idx     = '0;
                        w_wr_idx_nxt = ADDR_WIDTH'(1);
                        w_state_nxt  = ST_FILL;
                    end else begin
                        w_skip_cnt_nxt = r_skip_cnt + SKW'(1);
                    end
                end
                ST_FILL: begin
                    w_wr_en = 1'b1;
                    if (r_wr_idx == ADDR_WIDTH'(LINE_LENGTH - 1)) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_wr_idx_nxt = r_wr_idx + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Completion and release always target different banks, so both apply.
    always_comb begin
        w_release        = line_release && r_bank_valid[r_rd_bank];
        w_bank_valid_nxt = r_bank_valid;
        if (w_complete) begin
            w_bank_valid_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_bank_valid_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_skip_cnt   <= '0;
            r_wr_idx     <= '0;
            r_bank_valid <= 2'b00;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_skip_cnt   <= w_skip_cnt_nxt;
            r_wr_idx     <= w_wr_idx_nxt;
            r_bank_valid <= w_bank_valid_nxt;
            if (w_complete) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign overflow   = line_start && r_bank_valid[r_wr_bank];
    assign busy       = (r_state != ST_IDLE) ||
                        ((SKIP == 0) && line_start && !r_bank_valid[r_wr_bank]);
    assign line_ready = r_bank_valid[r_rd_bank];

    nabp_dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({r_wr_bank, w_wr_idx}),
        .i_wr_data (val_in),
        .i_rd_addr ({r_rd_bank, rd_addr}),
        .o_rd_data (rd_data)
    );

endmodule

// File: tb/tb_nabp_filtered_line_buffer.sv
// Scoreboard bench for the filtered line buffer: a line-level model
// (FIFO of up to two captured lines) predicts every cycle's outputs.
module tb_nabp_filtered_line_buffer;

    localparam int DW = 16;
    localparam int L  = 8;
    localparam int SK = 3;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          line_start;
    logic          line_release;
    logic [DW-1:0] val_in;
    logic [AW-1:0] rd_addr;
    logic          busy;
    logic          overflow;
    logic          line_ready;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    nabp_filtered_line_buffer #(
        .DATA_WIDTH  (DW),
        .LINE_LENGTH (L),
        .SKIP        (SK),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .line_start   (line_start),
        .val_in       (val_in),
        .busy         (busy),
        .overflow     (overflow),
        .line_ready   (line_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .line_release (line_release)
    );

    typedef struct {
        int            cyc;
        bit            chk;
        bit            ready;
        bit            busy;
        bit            ovf;
        bit            rd_chk;
        logic [DW-1:0] rd_val;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;

    // Reference model: stored lines identified by their line_start cycle.
    int            fifo[$];
    int            pend      = -1;
    bit            armed     = 1'b0;
    bit            nxt_rd_v  = 1'b0;
    logic [DW-1:0] nxt_rd_val = '0;

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, c, act, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("line_ready", e.cyc, {31'd0, line_ready}, {31'd0, e.ready});
                    check("busy",       e.cyc, {31'd0, busy},       {31'd0, e.busy});
                    check("overflow",   e.cyc, {31'd0, overflow},   {31'd0, e.ovf});
                    if (e.rd_chk) begin
                        check("rd_data", e.cyc, {16'd0, rd_data}, {16'd0, e.rd_val});
                    end
                end
            end
        end
    end

    task automatic step(input bit ls, input bit rel, input int addr, input bit rst);
        exp_t e;
        int   sz;
        bit   done;
        @(posedge clk);
        #1;
        cyc++;
        reset        = rst;
        line_start   = ls;
        line_release = rel;
        rd_addr      = AW'(addr);
        val_in       = DW'(cyc);
        sz           = fifo.size();
        e.cyc    = cyc;
        e.chk    = armed && !rst;
        e.ready  = (sz > 0);
        e.busy   = (pend >= 0) || (SK == 0 && ls && sz < 2);
        e.ovf    = ls && (sz >= 2);
        e.rd_chk = nxt_rd_v;
        e.rd_val = nxt_rd_val;
        exp_q.push_back(e);
        if (rst) begin
            nxt_rd_v   = 1'b1;
            nxt_rd_val = '0;
        end else if (sz > 0) begin
            nxt_rd_v   = 1'b1;
            nxt_rd_val = DW'(fifo[0] + SK + addr);
        end else begin
            nxt_rd_v = 1'b0;
        end
        if (rst) begin
            fifo.delete();
            pend  = -1;
            armed = 1'b1;
        end else begin
            done = (pend >= 0) && !ls && (cyc == pend + SK + L - 1);
            if (rel && sz > 0) void'(fifo.pop_front());
            if (done) begin
                fifo.push_back(pend);
                pend = -1;
            end
            if (ls && sz < 2) pend = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, L - 1), 1'b0);
    endtask

    task automatic sweep();
        for (int k = 0; k < L; k++) step(1'b0, 1'b0, k, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        line_start   = 1'b0;
        line_release = 1'b0;
        rd_addr      = '0;
        val_in       = '0;
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        idle(3);

        // single line
        step(1'b1, 1'b0, 0, 1'b0);
        idle(12);
        sweep();
        step(1'b0, 1'b1, 0, 1'b0);
        idle(3);

        // ping-pong fill, overflow on third start, ordered release
        step(1'b1, 1'b0, 0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 0, 1'b0);
        idle(2);
        sweep();
        step(1'b0, 1'b1, 0, 1'b0);
        sweep();
        step(1'b0, 1'b1, 0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 0, 1'b0);
        idle(2);

        // abort and restart
        step(1'b1, 1'b0, 0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 0, 1'b0);
        idle(14);
        sweep();
        step(1'b0, 1'b1, 0, 1'b0);
        idle(2);

        // release bank 0 in the cycle bank 1 completes
        step(1'b1, 1'b0, 0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 0, 1'b0);
        idle(9);
        step(1'b0, 1'b1, 0, 1'b0);
        idle(2);
        sweep();
        step(1'b0, 1'b1, 0, 1'b0);
        idle(2);

        // reset mid-fill with a stored line, then a stray release
        step(1'b1, 1'b0, 0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 0, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b1, 0, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 0, 1'b0);
        idle(14);
        sweep();
        step(1'b0, 1'b1, 0, 1'b0);

        // back-to-back lines at the minimum spacing, consumed as they arrive
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, $urandom_range(0, L - 1), 1'b0);
            for (int j = 0; j < SK + L - 1; j++)
                step(1'b0, (j == 5), $urandom_range(0, L - 1), 1'b0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0),
                 $urandom_range(0, L - 1), ($urandom_range(0, 599) == 0));
        end

        idle(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
